// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state codes, widths and default timing for the reset sequencer
package reset_seq_pkg;
    localparam int STATE_W = 3;
    localparam int DEF_NSTAGES = 4;
    localparam int DEF_HOLD_CYCLES = 4194303;
    localparam int DEF_ACK_TIMEOUT = 65535;
    localparam int DEF_SOFT_DELAY = 1023;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LINK = 3'd0,
        HOLD      = 3'd1,
        RELEASE   = 3'd2,
        WAIT_ACK  = 3'd3,
        RUN       = 3'd4,
        SOFT_WAIT = 3'd5
    } state_t;

    function automatic int timer_max(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? m : 1;
    endfunction
endpackage

// File: rtl/reset_seq_timer.sv
// reset_seq_timer: loadable up/down counter shared by the hold, ack and soft-delay phases
module reset_seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) count <= '0;
        else count <= load ? value : up ? count + WIDTH'(1) : down ? count - WIDTH'(1) : count;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases downstream reset domains in order once the link is stable
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NSTAGES     = DEF_NSTAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int SOFT_DELAY  = DEF_SOFT_DELAY
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               soft_reset_i,
    input  logic               link_ok_i,
    input  logic [NSTAGES-1:0] stage_ready_i,
    output logic [NSTAGES-1:0] stage_reset_o,
    output logic [2:0]         state_o,
    output logic [7:0]         timeout_cnt_o,
    output logic               busy_o
);
    localparam int KW = NSTAGES > 1 ? $clog2(NSTAGES) : 1;
    localparam int TW = $clog2(timer_max(HOLD_CYCLES, ACK_TIMEOUT, SOFT_DELAY) + 1);
    localparam logic [TW-1:0] HOLD_END  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] ACK_END   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] SOFT_LOAD = TW'(SOFT_DELAY);

    state_t             state, state_nx;
    logic [KW-1:0]      k, k_nx;
    logic [NSTAGES-1:0] rst_nx;
    logic [7:0]         tmo_nx;
    logic [TW-1:0]      timer, t_val;
    logic               t_load, t_up, t_dn;
    logic               active, ready_k, last_k;

    reset_seq_timer #(.WIDTH(TW)) timer_i (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .load     (t_load),
        .value    (t_val),
        .up       (t_up),
        .down     (t_dn),
        .count    (timer)
    );

    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state         <= WAIT_LINK;
            k             <= '0;
            stage_reset_o <= '1;
            timeout_cnt_o <= '0;
        end else begin
            state         <= state_nx;
            k             <= k_nx;
            stage_reset_o <= rst_nx;
            timeout_cnt_o <= tmo_nx;
        end

    // Codes 6-7 fall into the default branch and behave exactly like WAIT_LINK.
    always_comb begin
        active   = state inside {HOLD, RELEASE, WAIT_ACK, RUN, SOFT_WAIT};
        ready_k  = stage_ready_i[k];
        last_k   = k == KW'(NSTAGES - 1);
        state_nx = state;
        k_nx     = k;
        rst_nx   = stage_reset_o;
        tmo_nx   = timeout_cnt_o;
        t_load   = 1'b0;
        t_val    = '0;
        t_up     = 1'b0;
        t_dn     = 1'b0;
        if (active && !link_ok_i) begin
            state_nx = WAIT_LINK;
            k_nx     = '0;
            rst_nx   = '1;
            t_load   = 1'b1;
        end else if (active && soft_reset_i) begin
            state_nx = SOFT_WAIT;
            t_load   = 1'b1;
            t_val    = SOFT_LOAD;
        end else begin
            case (state)
                HOLD:
                    if (timer == HOLD_END) begin
                        state_nx = RELEASE;
                        k_nx     = '0;
                    end else t_up = 1'b1;
                RELEASE: begin
                    rst_nx[k] = 1'b0;
                    state_nx  = WAIT_ACK;
                    t_load    = 1'b1;
                end
                WAIT_ACK:
                    if (!ready_k && timer == ACK_END) begin
                        tmo_nx   = &timeout_cnt_o ? timeout_cnt_o : timeout_cnt_o + 8'd1;
                        rst_nx   = '1;
                        state_nx = HOLD;
                        t_load   = 1'b1;
                    end else if (ready_k) begin
                        state_nx = last_k ? RUN : RELEASE;
                        k_nx     = last_k ? k : k + KW'(1);
                    end else t_up = 1'b1;
                RUN: ;
                // Asserting on the edge where the count would hit zero keeps SOFT_WAIT exactly SOFT_DELAY cycles long.
                SOFT_WAIT:
                    if (timer <= TW'(1)) begin
                        rst_nx   = '1;
                        state_nx = HOLD;
                        t_load   = 1'b1;
                    end else t_dn = 1'b1;
                default: begin
                    rst_nx   = '1;
                    k_nx     = '0;
                    t_load   = 1'b1;
                    state_nx = link_ok_i ? HOLD : WAIT_LINK;
                end
            endcase
        end
    end

    always_comb begin
        state_o = state;
        busy_o  = state != RUN;
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios with a cycle-stamped expectation scoreboard
module tb_reset_sequencer;
    logic       clock_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       soft_reset_i = 1'b0;
    logic       link_ok_i = 1'b0;
    logic [3:0] stage_ready_i = '0;
    logic [3:0] stage_reset_o;
    logic [2:0] state_o;
    logic [7:0] timeout_cnt_o;
    logic       busy_o;

    logic [3:0] mask = 4'hF;
    logic       probe = 1'b0;
    logic       done = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         cnt [4] = '{default: 0};

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [3:0] rs;
        logic [7:0] tc;
        logic       b;
        string      name;
    } exp_t;
    exp_t q[$];

    reset_sequencer #(
        .NSTAGES    (4),
        .HOLD_CYCLES(16),
        .ACK_TIMEOUT(8),
        .SOFT_DELAY (32)
    ) dut (
        .clock_i      (clock_i),
        .reset_n_i    (reset_n_i),
        .soft_reset_i (soft_reset_i),
        .link_ok_i    (link_ok_i),
        .stage_ready_i(stage_ready_i),
        .stage_reset_o(stage_reset_o),
        .state_o      (state_o),
        .timeout_cnt_o(timeout_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc <= cyc + 1;

    // Each domain reports ready two cycles after its reset drops (unless masked).
    always @(negedge clock_i)
        for (int j = 0; j < 4; j++) begin
            cnt[j] = stage_reset_o[j] ? 0 : (cnt[j] < 2 ? cnt[j] + 1 : 2);
            stage_ready_i[j] = mask[j] && cnt[j] == 2;
        end

    always @(negedge clock_i or posedge probe) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || state_o !== e.st || stage_reset_o !== e.rs ||
                timeout_cnt_o !== e.tc || busy_o !== e.b) begin
                failures++;
                $display("FAIL %s cyc=%0d(due %0d) got st=%0d rs=%b tc=%0d busy=%b want st=%0d rs=%b tc=%0d busy=%b",
                         e.name, cyc, e.cyc, state_o, stage_reset_o, timeout_cnt_o, busy_o,
                         e.st, e.rs, e.tc, e.b);
            end
        end
        if (done)
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL %s never observed (due cyc %0d, now %0d)", e.name, e.cyc, cyc);
            end
    end

    task automatic push(int c, logic [2:0] st, logic [3:0] rs, logic [7:0] tc, logic b, string name);
        exp_t e;
        e.cyc = c; e.st = st; e.rs = rs; e.tc = tc; e.b = b; e.name = name;
        q.push_back(e);
    endtask

    task automatic push_seq(int h, logic [7:0] tc);
        push(h,      3'd1, 4'hF, tc, 1'b1, "hold");
        push(h + 16, 3'd2, 4'hF, tc, 1'b1, "rel0");
        push(h + 17, 3'd3, 4'hE, tc, 1'b1, "ack0");
        push(h + 19, 3'd2, 4'hE, tc, 1'b1, "rel1");
        push(h + 20, 3'd3, 4'hC, tc, 1'b1, "ack1");
        push(h + 23, 3'd3, 4'h8, tc, 1'b1, "ack2");
        push(h + 26, 3'd3, 4'h0, tc, 1'b1, "ack3");
        push(h + 28, 3'd4, 4'h0, tc, 1'b0, "run");
    endtask

    task automatic at(int c);
        while (cyc < c) @(negedge clock_i);
    endtask

    task automatic soft_pulse();
        soft_reset_i = 1'b1;
        @(negedge clock_i);
        soft_reset_i = 1'b0;
    endtask

    initial begin
        int c, h;
        @(negedge clock_i);
        c = cyc;
        push(c + 1, 3'd0, 4'hF, 8'd0, 1'b1, "reset_state");
        push(c + 3, 3'd0, 4'hF, 8'd0, 1'b1, "wait_link");
        at(c + 2);
        reset_n_i = 1'b1;
        at(c + 4);
        link_ok_i = 1'b1;
        push_seq(c + 5, 8'd0);
        at(c + 35);

        c = cyc; h = c + 33;
        push(c + 1,  3'd5, 4'h0, 8'd0, 1'b1, "soft_enter");
        push(c + 32, 3'd5, 4'h0, 8'd0, 1'b1, "soft_last");
        push_seq(h, 8'd0);
        soft_pulse();
        at(h + 30);

        c = cyc; h = c + 43;
        push(c + 1,  3'd5, 4'h0, 8'd0, 1'b1, "soft2_enter");
        push(c + 33, 3'd5, 4'h0, 8'd0, 1'b1, "soft2_reloaded");
        push(c + 42, 3'd5, 4'h0, 8'd0, 1'b1, "soft2_last");
        push_seq(h, 8'd0);
        soft_pulse();
        at(c + 10);
        soft_pulse();
        at(h + 30);

        c = cyc; h = c + 33;
        mask = 4'b1011;
        push(c + 1,          3'd5, 4'h0, 8'd0,   1'b1, "to_soft");
        push(h,              3'd1, 4'hF, 8'd0,   1'b1, "hold_t");
        push(h + 23,         3'd3, 4'h8, 8'd0,   1'b1, "ack2_wait");
        push(h + 30,         3'd3, 4'h8, 8'd0,   1'b1, "ack2_last");
        push(h + 31,         3'd1, 4'hF, 8'd1,   1'b1, "timeout1");
        push(h + 62,         3'd1, 4'hF, 8'd2,   1'b1, "timeout2");
        push(h + 31 * 255,   3'd1, 4'hF, 8'd255, 1'b1, "timeout255");
        push_seq(h + 31 * 300, 8'd255);
        soft_pulse();
        at(h + 31 * 300);
        mask = 4'hF;
        at(h + 31 * 300 + 30);

        c = cyc; h = c + 33;
        push(c + 1,  3'd5, 4'h0, 8'd255, 1'b1, "soft_e");
        push(h,      3'd1, 4'hF, 8'd255, 1'b1, "hold_e");
        push(h + 17, 3'd3, 4'hE, 8'd255, 1'b1, "ack0_e");
        push(h + 18, 3'd0, 4'hF, 8'd255, 1'b1, "link_loss");
        push(h + 19, 3'd0, 4'hF, 8'd255, 1'b1, "no_soft_wait");
        push(h + 21, 3'd0, 4'hF, 8'd255, 1'b1, "soft_ignored");
        push_seq(h + 23, 8'd255);
        soft_pulse();
        at(h + 17);
        link_ok_i = 1'b0;
        soft_reset_i = 1'b1;
        at(h + 18);
        soft_reset_i = 1'b0;
        at(h + 20);
        soft_reset_i = 1'b1;
        at(h + 21);
        soft_reset_i = 1'b0;
        at(h + 22);
        link_ok_i = 1'b1;
        at(h + 53);

        c = cyc; h = c + 33;
        push(c + 1,  3'd5, 4'h0, 8'd255, 1'b1, "soft_f");
        push(h + 20, 3'd3, 4'hC, 8'd255, 1'b1, "ack1_f");
        soft_pulse();
        at(h + 21);
        #1 reset_n_i = 1'b0;
        push(h + 21, 3'd0, 4'hF, 8'd0, 1'b1, "async_reset");
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        at(h + 23);
        reset_n_i = 1'b1;
        push_seq(h + 24, 8'd0);
        at(h + 54);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clock_i);
        done = 1'b1;
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
